// File: rtl/inner_probe_pkg.sv
// Shared InnerProbe definitions: PRBS-7 polynomial/seed and checker state encoding.
// Used by both the probe generator and the receive-side checker.
package inner_probe_pkg;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  // x^7 + x^6 + 1: taps on lfsr[6] and lfsr[5]
  localparam logic [6:0] PRBS7_TAPS = 7'h60;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } probe_state_e;

  function automatic logic prbs7_predict(input logic [6:0] lfsr);
    return ^(lfsr & PRBS7_TAPS);
  endfunction

endpackage

// File: rtl/inner_probe_sync.sv
// Two-flop synchroniser for one asynchronous probe line.
module inner_probe_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inner_probe_checker.sv
// InnerProbe receive checker: PRBS-7 self-sync and lock, bit/error counters,
// xor-line consistency count and square-wave period meter.
//
//   state  | meaning
//   SEARCH | LFSR loads received bits; counting consecutive correct predictions
//   LOCKED | LFSR free-runs on its own prediction; errors counted per window
module inner_probe_checker
  import inner_probe_pkg::*;
#(
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_WINDOW = 64,
  parameter int LOSS_ERRORS = 8,
  parameter int ERR_CNT_W   = 32,
  parameter int PERIOD_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_in,
  input  logic                 square_in,
  input  logic                 xor_in,
  input  logic                 clear,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] bit_count,
  output logic [ERR_CNT_W-1:0] xor_err_count,
  output logic [PERIOD_W-1:0]  sq_period,
  output logic                 sq_valid
);

  localparam int MW  = $clog2(LOCK_THRESH + 1);
  localparam int WBW = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int EW  = $clog2(LOSS_ERRORS + 1);
  localparam logic [MW-1:0]  MATCH_MAX = MW'(LOCK_THRESH);
  localparam logic [WBW-1:0] WB_LAST   = WBW'(LOSS_WINDOW - 1);
  localparam logic [EW-1:0]  ERR_LIMIT = EW'(LOSS_ERRORS);

  logic data_s, sq_s, xor_s;

  inner_probe_sync u_sync_data (.clk(clk), .reset_n(reset_n), .d(data_in),   .q(data_s));
  inner_probe_sync u_sync_sq   (.clk(clk), .reset_n(reset_n), .d(square_in), .q(sq_s));
  inner_probe_sync u_sync_xor  (.clk(clk), .reset_n(reset_n), .d(xor_in),    .q(xor_s));

  probe_state_e   state_q, state_d;
  logic [6:0]     lfsr_q, lfsr_d;
  logic [MW-1:0]  match_q, match_d;
  logic [WBW-1:0] wbits_q, wbits_d;
  logic [EW-1:0]  werr_q, werr_d, werr_inc;
  logic           pred, miss, check;

  always_comb begin
    pred     = prbs7_predict(lfsr_q);
    miss     = data_s ^ pred;
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    match_d  = match_q;
    wbits_d  = '0;
    werr_d   = '0;
    check    = 1'b0;
    werr_inc = werr_q + EW'(miss);
    case (state_q)
      SEARCH: begin
        lfsr_d = {lfsr_q[5:0], data_s};
        if (miss)
          match_d = '0;
        else if (match_q != MATCH_MAX)
          match_d = match_q + MW'(1);
        // an all-zero LFSR predicts zeros forever, so it must never count as lock
        if (match_d == MATCH_MAX && lfsr_d != '0)
          state_d = LOCKED;
      end
      LOCKED: begin
        lfsr_d = {lfsr_q[5:0], pred};
        check  = 1'b1;
        if (werr_inc >= ERR_LIMIT) begin
          state_d = SEARCH;
          match_d = '0;
        end else if (wbits_q != WB_LAST) begin
          wbits_d = wbits_q + WBW'(1);
          werr_d  = werr_inc;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      lfsr_q  <= PRBS7_SEED;
      match_q <= '0;
      wbits_q <= '0;
      werr_q  <= '0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      match_q <= match_d;
      wbits_q <= wbits_d;
      werr_q  <= werr_d;
      locked  <= (state_q == LOCKED);
    end
  end

  logic xor_miss;
  assign xor_miss = xor_s ^ data_s ^ sq_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count     <= '0;
      bit_count     <= '0;
      xor_err_count <= '0;
    end else if (clear) begin
      err_count     <= '0;
      bit_count     <= '0;
      xor_err_count <= '0;
    end else begin
      if (check && bit_count != '1)
        bit_count <= bit_count + ERR_CNT_W'(1);
      if (check && miss && err_count != '1)
        err_count <= err_count + ERR_CNT_W'(1);
      if (xor_miss && xor_err_count != '1)
        xor_err_count <= xor_err_count + ERR_CNT_W'(1);
    end
  end

  logic                sq_d, sq_rise;
  logic [PERIOD_W-1:0] sq_cnt, sq_cnt_inc;
  assign sq_rise    = sq_s & ~sq_d;
  assign sq_cnt_inc = (sq_cnt == '1) ? sq_cnt : sq_cnt + PERIOD_W'(1);

  // period reported is edge-to-edge in clocks, hence count+1 at the rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sq_d      <= 1'b0;
      sq_cnt    <= '0;
      sq_period <= '0;
      sq_valid  <= 1'b0;
    end else begin
      sq_d     <= sq_s;
      sq_valid <= sq_rise;
      if (sq_rise) begin
        sq_period <= sq_cnt_inc;
        sq_cnt    <= '0;
      end else begin
        sq_cnt <= sq_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_inner_probe_checker.sv
// Directed bench for inner_probe_checker: lock, error injection, relock,
// square period, xor-line errors with clear, and mid-lock reset.
module tb_inner_probe_checker;

  logic        clk = 1'b0;
  logic        reset_n, data_in, square_in, xor_in, clear;
  logic        locked, sq_valid;
  logic [31:0] err_count, bit_count, xor_err_count;
  logic [15:0] sq_period;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         sq_start = 0;
  logic [6:0] g = 7'h7F;
  logic       gen_en = 1'b0;
  logic       sq_en = 1'b0;

  always #5 clk = ~clk;

  inner_probe_checker dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .square_in(square_in),
    .xor_in(xor_in), .clear(clear), .locked(locked), .err_count(err_count),
    .bit_count(bit_count), .xor_err_count(xor_err_count),
    .sq_period(sq_period), .sq_valid(sq_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Drives one cycle of stimulus; after return, cyc is the number of the edge just taken.
  task automatic tick(input logic flip_d, input logic flip_x, input logic clr);
    logic b;
    b = 1'b0;
    if (gen_en) begin
      b = g[6] ^ g[5];
      g = {g[5:0], b};
    end
    data_in   = b ^ flip_d;
    square_in = sq_en && (((cyc + 1 - sq_start) % 20) < 10);
    xor_in    = data_in ^ square_in ^ flip_x;
    clear     = clr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    data_in   = 1'b0;
    square_in = 1'b0;
    xor_in    = 1'b0;
    clear     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", err_count, 32'd0);
    chk("rst_bits", bit_count, 32'd0);
    chk("rst_xor", xor_err_count, 32'd0);
    chk("rst_period", 32'(sq_period), 32'd0);
    chk("rst_valid", 32'(sq_valid), 32'd0);

    reset_n = 1'b1;
    cyc = 0;

    // all-zero stream: LFSR collapses to 0 and must not lock
    run_to(40);
    chk("zero_nolock", 32'(locked), 32'd0);
    chk("zero_bits", bit_count, 32'd0);

    // PRBS from seed 7F: bits 0..5 are zero, bit 6 (edge 47, checked 49) is the first 1;
    // 16 matches on edges 50..65 -> LOCKED at 65, locked output at 66
    gen_en = 1'b1;
    run_to(65);
    chk("lock_pre", 32'(locked), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("lock_rise", 32'(locked), 32'd1);
    chk("lock_bits1", bit_count, 32'd1);
    chk("lock_err0", err_count, 32'd0);
    run_to(100);
    chk("bits_rate", bit_count, 32'd35);
    chk("clean_err", err_count, 32'd0);

    // single flipped bit, driven edge 148, checked edge 150
    run_to(147);
    tick(1'b1, 1'b0, 1'b0);
    run_to(160);
    chk("single_err", err_count, 32'd1);
    chk("single_locked", 32'(locked), 32'd1);
    chk("single_bits", bit_count, 32'd95);

    run_to(199);
    tick(1'b0, 1'b0, 1'b1);
    chk("clear_bits", bit_count, 32'd0);
    chk("clear_err", err_count, 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("post_clear_bits", bit_count, 32'd1);

    // 8 flips checked on edges 270..277, inside window 258..321
    run_to(267);
    repeat (8) tick(1'b1, 1'b0, 1'b0);
    run_to(277);
    chk("burst_still_locked", 32'(locked), 32'd1);
    chk("burst_err", err_count, 32'd8);
    tick(1'b0, 1'b0, 1'b0);
    chk("burst_drop", 32'(locked), 32'd0);
    run_to(293);
    chk("relock_pre", 32'(locked), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_bits", bit_count, 32'd78);
    chk("relock_err", err_count, 32'd8);

    // square 10 high / 10 low, first rising drive at edge 301, detected at 303
    run_to(300);
    sq_start = 301;
    sq_en = 1'b1;
    run_to(302);
    chk("sq_valid_pre", 32'(sq_valid), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("sq_first_valid", 32'(sq_valid), 32'd1);
    chk("sq_first_period", 32'(sq_period), 32'd303);
    tick(1'b0, 1'b0, 1'b0);
    chk("sq_valid_pulse", 32'(sq_valid), 32'd0);
    run_to(322);
    chk("sq_valid_gap", 32'(sq_valid), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("sq_valid2", 32'(sq_valid), 32'd1);
    chk("sq_period2", 32'(sq_period), 32'd20);
    run_to(343);
    chk("sq_valid3", 32'(sq_valid), 32'd1);
    chk("sq_period3", 32'(sq_period), 32'd20);

    // three inverted xor samples
    run_to(349);
    tick(1'b0, 1'b1, 1'b0);
    run_to(354);
    tick(1'b0, 1'b1, 1'b0);
    run_to(359);
    tick(1'b0, 1'b1, 1'b0);
    run_to(365);
    chk("xor_err3", xor_err_count, 32'd3);

    // xor error counted on edge 370 coincides with clear
    run_to(367);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("xor_before_clear", xor_err_count, 32'd3);
    tick(1'b0, 1'b0, 1'b1);
    chk("xor_clear_wins", xor_err_count, 32'd0);
    chk("bits_clear_wins", bit_count, 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("xor_after_clear", xor_err_count, 32'd0);
    chk("bits_after_clear", bit_count, 32'd1);

    run_to(380);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    chk("pre_rst_bits", bit_count, 32'd10);
    chk("pre_rst_period", 32'(sq_period), 32'd20);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_bits", bit_count, 32'd0);
    chk("midrst_err", err_count, 32'd0);
    chk("midrst_xor", xor_err_count, 32'd0);
    chk("midrst_period", 32'(sq_period), 32'd0);
    chk("midrst_valid", 32'(sq_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
